rf_wport_arbiter: RTL and testbench

Controller that shares the single register-file write port between the in-order WB stage and a long-latency unit (LU, e.g. mul/div or refill return).
- WB has priority.
- LU results queue in a small FIFO and drain when the port is idle, or when a starvation limit forces a grant.
- Exports a pending-destination mask so ID can stall reads of registers still waiting in the FIFO.
- Sits between wb_stage/LU and the regfile.

---
 rtl/rf_wport_arbiter_pkg.sv | 24 ++
 rtl/rf_arb_fifo.sv | 93 +++++++++
 rtl/rf_wport_arbiter.sv | 130 +++++++++++++
 tb/tb_rf_wport_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: address width, FIFO entry tag
// layout and the packed port bus width (ARB_TO_RF_BUS_WD, same packing as WS_TO_RF_BUS).
`ifndef ARB_TO_RF_BUS_WD
`define ARB_TO_RF_BUS_WD (1 + 5 + DATA_W)
`endif

package rf_wport_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_NREGS  = 32;

    typedef enum logic {
        SRC_WB = 1'b0,
        SRC_LU = 1'b1
    } rf_src_e;

    // Entry layout is {valid, waddr, wdata}; wdata lives in a separate array
    // because its width is a module parameter.
    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] waddr;
    } ent_tag_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// LU result FIFO: storage, pointers, occupancy, squash-by-address of queued
// entries and the decode of pending destinations.
module rf_arb_fifo
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic [RF_ADDR_W-1:0] push_waddr,
    input  logic [DATA_W-1:0]    push_wdata,
    input  logic                 pop,
    input  logic                 squash_en,
    input  logic [RF_ADDR_W-1:0] squash_addr,
    output logic                 full,
    output logic                 empty,
    output logic                 head_valid,
    output logic [RF_ADDR_W-1:0] head_waddr,
    output logic [DATA_W-1:0]    head_wdata,
    output logic [RF_NREGS-1:0]  pend_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ent_tag_t          tag_q  [DEPTH];
    ent_tag_t          tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full       = (cnt_q == CNT_W'(DEPTH));
    assign empty      = (cnt_q == '0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign head_valid = !empty && tag_q[rd_ptr_q].valid;
    assign head_waddr = tag_q[rd_ptr_q].waddr;
    assign head_wdata = data_q[rd_ptr_q];

    always_comb begin
        tag_d  = tag_q;
        data_d = data_q;
        // A younger WB write to the same register makes the queued result stale.
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && tag_q[i].valid && tag_q[i].waddr == squash_addr)
                tag_d[i].valid = 1'b0;
        end
        if (pop_ok)
            tag_d[rd_ptr_q].valid = 1'b0;
        if (push_ok) begin
            tag_d[wr_ptr_q].valid  = 1'b1;
            tag_d[wr_ptr_q].waddr  = push_waddr;
            data_d[wr_ptr_q]       = push_wdata;
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                tag_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            tag_q    <= tag_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tag_q[i].valid)
                pend_mask[tag_q[i].waddr] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port between WB (priority) and a queued long-latency unit,
// with a starvation-forced grant. Optional perf counters under RF_ARB_PERF_EN.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int LU_FIFO_DEPTH = 2,
    parameter int STARVE_MAX    = 4,
    parameter int DATA_W        = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ws_rf_valid,
    input  logic [RF_ADDR_W-1:0] ws_rf_waddr,
    input  logic [DATA_W-1:0]    ws_rf_wdata,
    output logic                 ws_rf_ready,
    input  logic                 lu_valid,
    input  logic [RF_ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0]    lu_wdata,
    output logic                 lu_ready,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 rf_src,
    output logic [RF_NREGS-1:0]  lu_pend_mask
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]          perf_conflict_cnt,
    output logic [31:0]          perf_forced_cnt
`endif
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic                 fifo_full, fifo_empty, head_valid;
    logic [RF_ADDR_W-1:0] head_waddr;
    logic [DATA_W-1:0]    head_wdata;
    logic                 fifo_grant, ws_grant, inv_pop, fifo_pop, fifo_push, squash_en;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    rf_src_e              src;
    logic                 port_we;
    logic [RF_ADDR_W-1:0] port_waddr;
    logic [DATA_W-1:0]    port_wdata;
    logic [`ARB_TO_RF_BUS_WD-1:0] arb_to_rf_bus;

    assign fifo_grant = head_valid && (!ws_rf_valid || starve_q == STARVE_W'(STARVE_MAX));
    assign ws_rf_ready = resetn && !fifo_grant;
    assign ws_grant    = ws_rf_valid && ws_rf_ready;
    // Stale (squashed) heads are retired only in cycles WB leaves the port unused.
    assign inv_pop     = !fifo_empty && !head_valid && !ws_rf_valid;
    assign fifo_pop    = fifo_grant || inv_pop;
    assign lu_ready    = resetn && !fifo_full;
    assign fifo_push   = lu_valid && lu_ready;
    assign squash_en   = ws_grant && (ws_rf_waddr != '0);

    rf_arb_fifo #(
        .DEPTH  (LU_FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (fifo_push),
        .push_waddr  (lu_waddr),
        .push_wdata  (lu_wdata),
        .pop         (fifo_pop),
        .squash_en   (squash_en),
        .squash_addr (ws_rf_waddr),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_valid  (head_valid),
        .head_waddr  (head_waddr),
        .head_wdata  (head_wdata),
        .pend_mask   (lu_pend_mask)
    );

    always_comb begin
        starve_d = starve_q;
        if (fifo_grant || fifo_empty)
            starve_d = '0;
        else if (head_valid && starve_q != STARVE_W'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end

    always_comb begin
        src = fifo_pop ? SRC_LU : SRC_WB;
        if (fifo_grant) begin
            port_we    = (head_waddr != '0);
            port_waddr = head_waddr;
            port_wdata = head_wdata;
        end else begin
            port_we    = ws_grant && (ws_rf_waddr != '0);
            port_waddr = ws_rf_waddr;
            port_wdata = ws_rf_wdata;
        end
    end

    assign arb_to_rf_bus              = {port_we, port_waddr, port_wdata};
    assign {rf_we, rf_waddr, rf_wdata} = arb_to_rf_bus;
    assign rf_src                     = src;

`ifdef RF_ARB_PERF_EN
    logic [31:0] conflict_q, conflict_d;
    logic [31:0] forced_q, forced_d;

    always_comb begin
        conflict_d = conflict_q + 32'(ws_rf_valid && head_valid);
        forced_d   = forced_q + 32'(fifo_grant && ws_rf_valid);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conflict_q <= '0;
            forced_q   <= '0;
        end else begin
            conflict_q <= conflict_d;
            forced_q   <= forced_d;
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_forced_cnt   = forced_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: reset, LU drain, starvation, full FIFO,
// WAW squash, $0 writes and mid-operation reset.
module tb_rf_wport_arbiter;

    logic        clk;
    logic        resetn;
    logic        ws_rf_valid;
    logic [4:0]  ws_rf_waddr;
    logic [31:0] ws_rf_wdata;
    logic        ws_rf_ready;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic [31:0] lu_pend_mask;
`ifdef RF_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_forced_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rf_mem [32];

    rf_wport_arbiter #(
        .LU_FIFO_DEPTH (2),
        .STARVE_MAX    (4),
        .DATA_W        (32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ws_rf_valid  (ws_rf_valid),
        .ws_rf_waddr  (ws_rf_waddr),
        .ws_rf_wdata  (ws_rf_wdata),
        .ws_rf_ready  (ws_rf_ready),
        .lu_valid     (lu_valid),
        .lu_waddr     (lu_waddr),
        .lu_wdata     (lu_wdata),
        .lu_ready     (lu_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_src       (rf_src),
        .lu_pend_mask (lu_pend_mask)
`ifdef RF_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_forced_cnt   (perf_forced_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in regfile capturing whatever the port writes.
    always @(posedge clk) begin
        if (rf_we)
            rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            rf_mem[i] = 32'h0;
        resetn      = 1'b0;
        ws_rf_valid = 1'b1;
        ws_rf_waddr = 5'd3;
        ws_rf_wdata = 32'h33;
        lu_valid    = 1'b0;
        lu_waddr    = 5'd0;
        lu_wdata    = 32'h0;

        // reset holds everything off even with WB requesting
        settle();
        check_eq("rst_rf_we", 32'(rf_we), 32'd0);
        check_eq("rst_ws_ready", 32'(ws_rf_ready), 32'd0);
        check_eq("rst_lu_ready", 32'(lu_ready), 32'd0);
        check_eq("rst_mask", lu_pend_mask, 32'h0);
        check_eq("rst_src", 32'(rf_src), 32'd0);
        next_cyc();
        resetn = 1'b1;
        settle();
        check_eq("rel_rf_we", 32'(rf_we), 32'd1);
        check_eq("rel_waddr", 32'(rf_waddr), 32'd3);
        check_eq("rel_ws_ready", 32'(ws_rf_ready), 32'd1);
        check_eq("rel_lu_ready", 32'(lu_ready), 32'd1);

        // LU only
        next_cyc();
        ws_rf_valid = 1'b0;
        lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hDEAD_BEEF;
        settle();
        check_eq("lu_mask_pre", lu_pend_mask, 32'h0);
        check_eq("r3_written", rf_mem[3], 32'h33);
        next_cyc();
        lu_valid = 1'b0;
        settle();
        check_eq("lu_mask", lu_pend_mask, 32'h20);
        check_eq("lu_rf_we", 32'(rf_we), 32'd1);
        check_eq("lu_src", 32'(rf_src), 32'd1);
        check_eq("lu_waddr", 32'(rf_waddr), 32'd5);
        check_eq("lu_wdata", rf_wdata, 32'hDEAD_BEEF);
        next_cyc();
        settle();
        check_eq("lu_mask_clr", lu_pend_mask, 32'h0);
        check_eq("lu_idle_we", 32'(rf_we), 32'd0);

        // starvation: r7 queued behind continuous WB traffic
        next_cyc();
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
        ws_rf_valid = 1'b1; ws_rf_waddr = 5'd1; ws_rf_wdata = 32'h101;
        settle();
        check_eq("stv_first_src", 32'(rf_src), 32'd0);
        next_cyc();
        lu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ws_rf_waddr = 5'(i + 2);
            ws_rf_wdata = 32'h100 + 32'(i + 2);
            settle();
            check_eq("stv_wb_src", 32'(rf_src), 32'd0);
            check_eq("stv_wb_ready", 32'(ws_rf_ready), 32'd1);
            check_eq("stv_wb_waddr", 32'(rf_waddr), 32'(i + 2));
            next_cyc();
        end
        ws_rf_waddr = 5'd6; ws_rf_wdata = 32'h106;
        settle();
        check_eq("stv_forced_src", 32'(rf_src), 32'd1);
        check_eq("stv_forced_waddr", 32'(rf_waddr), 32'd7);
        check_eq("stv_forced_ready", 32'(ws_rf_ready), 32'd0);
        check_eq("stv_forced_we", 32'(rf_we), 32'd1);
        check_eq("stv_forced_data", rf_wdata, 32'h77);
        next_cyc();
        settle();
        check_eq("stv_resume_ready", 32'(ws_rf_ready), 32'd1);
        check_eq("stv_resume_src", 32'(rf_src), 32'd0);
        check_eq("stv_resume_waddr", 32'(rf_waddr), 32'd6);

        // full FIFO with WB busy
        next_cyc();
        ws_rf_waddr = 5'd10; ws_rf_wdata = 32'hA;
        lu_valid = 1'b1; lu_waddr = 5'd11; lu_wdata = 32'hB;
        settle();
        check_eq("full_p_ready", 32'(lu_ready), 32'd1);
        next_cyc();
        lu_waddr = 5'd12; lu_wdata = 32'hC;
        settle();
        check_eq("full_q_ready", 32'(lu_ready), 32'd1);
        next_cyc();
        lu_waddr = 5'd13; lu_wdata = 32'hD;
        settle();
        check_eq("full_r_ready", 32'(lu_ready), 32'd0);
        check_eq("full_r_mask", lu_pend_mask, 32'h0000_1800);
        for (int i = 0; i < 2; i++) begin
            next_cyc();
            settle();
            check_eq("full_hold_ready", 32'(lu_ready), 32'd0);
            check_eq("full_hold_src", 32'(rf_src), 32'd0);
        end
        next_cyc();
        settle();
        check_eq("full_pop_ready", 32'(lu_ready), 32'd0);
        check_eq("full_pop_src", 32'(rf_src), 32'd1);
        check_eq("full_pop_waddr", 32'(rf_waddr), 32'd11);
        next_cyc();
        settle();
        check_eq("full_accept_ready", 32'(lu_ready), 32'd1);
        check_eq("full_accept_src", 32'(rf_src), 32'd0);
        check_eq("full_accept_mask", lu_pend_mask, 32'h0000_1000);
        next_cyc();
        lu_valid = 1'b0; ws_rf_valid = 1'b0;
        settle();
        check_eq("drain12_waddr", 32'(rf_waddr), 32'd12);
        check_eq("drain12_mask", lu_pend_mask, 32'h0000_3000);
        next_cyc();
        settle();
        check_eq("drain13_waddr", 32'(rf_waddr), 32'd13);
        check_eq("drain13_data", rf_wdata, 32'hD);
        next_cyc();
        settle();
        check_eq("drain_done_mask", lu_pend_mask, 32'h0);
        check_eq("drain_done_we", 32'(rf_we), 32'd0);

        // WAW squash
        next_cyc();
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h11;
        settle();
        next_cyc();
        lu_valid = 1'b0;
        ws_rf_valid = 1'b1; ws_rf_waddr = 5'd9; ws_rf_wdata = 32'h22;
        settle();
        check_eq("waw_ws_ready", 32'(ws_rf_ready), 32'd1);
        check_eq("waw_src", 32'(rf_src), 32'd0);
        check_eq("waw_mask", lu_pend_mask, 32'h200);
        next_cyc();
        ws_rf_valid = 1'b0;
        settle();
        check_eq("waw_sq_mask", lu_pend_mask, 32'h0);
        check_eq("waw_sq_we", 32'(rf_we), 32'd0);
        check_eq("waw_sq_src", 32'(rf_src), 32'd1);
        next_cyc();
        lu_valid = 1'b1; lu_waddr = 5'd20; lu_wdata = 32'h20;
        settle();
        next_cyc();
        lu_valid = 1'b0;
        settle();
        check_eq("waw_after_ready", 32'(lu_ready), 32'd1);
        check_eq("waw_after_mask", lu_pend_mask, 32'h0010_0000);
        check_eq("waw_after_waddr", 32'(rf_waddr), 32'd20);
        check_eq("waw_r9", rf_mem[9], 32'h22);
        next_cyc();

        // $0 writes from both sources
        ws_rf_valid = 1'b1; ws_rf_waddr = 5'd0; ws_rf_wdata = 32'hBAD;
        settle();
        check_eq("z_ws_ready", 32'(ws_rf_ready), 32'd1);
        check_eq("z_ws_we", 32'(rf_we), 32'd0);
        next_cyc();
        ws_rf_valid = 1'b0;
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hBAD;
        settle();
        next_cyc();
        lu_valid = 1'b0;
        settle();
        check_eq("z_lu_mask", lu_pend_mask, 32'h0);
        check_eq("z_lu_src", 32'(rf_src), 32'd1);
        check_eq("z_lu_we", 32'(rf_we), 32'd0);
        next_cyc();
        settle();
        check_eq("z_empty_src", 32'(rf_src), 32'd0);
        check_eq("z_r0", rf_mem[0], 32'h0);

        // reset mid-operation discards the queued result
        next_cyc();
        ws_rf_valid = 1'b1; ws_rf_waddr = 5'd2; ws_rf_wdata = 32'h202;
        lu_valid = 1'b1; lu_waddr = 5'd15; lu_wdata = 32'hF;
        settle();
        next_cyc();
        lu_valid = 1'b0;
        settle();
        check_eq("mrst_mask_pre", lu_pend_mask, 32'h0000_8000);
        resetn = 1'b0;
        #1;
        check_eq("mrst_mask", lu_pend_mask, 32'h0);
        check_eq("mrst_ws_ready", 32'(ws_rf_ready), 32'd0);
        check_eq("mrst_we", 32'(rf_we), 32'd0);
        next_cyc();
        resetn = 1'b1;
        ws_rf_valid = 1'b0;
        settle();
        check_eq("mrst_rel_mask", lu_pend_mask, 32'h0);
        check_eq("mrst_rel_we", 32'(rf_we), 32'd0);
        check_eq("mrst_rel_lu_ready", 32'(lu_ready), 32'd1);
        check_eq("r7_written", rf_mem[7], 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
